// File: rtl/alu_muldiv_unit_pkg.sv
// Shared types and opcode constants for the ALU with its iterative multiply/divide engine.
// Holds the ALU control codes, main-decoder classes, R-type function codes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    CTL_AND  = 4'b0000,
    CTL_OR   = 4'b0001,
    CTL_ADD  = 4'b0010,
    CTL_XOR  = 4'b0011,
    CTL_NOR  = 4'b0100,
    CTL_SLTU = 4'b0101,
    CTL_SUB  = 4'b0110,
    CTL_SLT  = 4'b0111,
    CTL_SLL  = 4'b1000,
    CTL_SRL  = 4'b1001,
    CTL_SRA  = 4'b1011
  } alu_ctl_e;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_ANDI  = 4'b1001;
  localparam logic [3:0] ALUOP_ORI   = 4'b1010;
  localparam logic [3:0] ALUOP_XORI  = 4'b1011;
  localparam logic [3:0] ALUOP_SLTI  = 4'b1100;
  localparam logic [3:0] ALUOP_SLTIU = 4'b1101;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;

  // Encoding matches Funct[1:0] of the MULT/MULTU/DIV/DIVU group.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Instruction/operand bundle between the issuing pipeline (master) and the ALU unit (slave).
interface alu_muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [3:0]       ALUOp;
  logic [5:0]       Funct;
  logic             in_valid;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;
  logic             busy;
  logic             stall;

  modport master (
    output ALUOp, Funct, in_valid, flush, a, b, shamt,
    input  result, zero, ovf, illegal, busy, stall
  );

  modport slave (
    input  ALUOp, Funct, in_valid, flush, a, b, shamt,
    output result, zero, ovf, illegal, busy, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, one bit per cycle,
// followed by a single FIX cycle in which the sign-corrected hi/lo are presented with done.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  md_state_e          state;
  logic [SHW-1:0]     iter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               is_div, neg_lo, neg_hi, div_zero;

  logic               op_signed, op_div, div_ge;
  logic [WIDTH-1:0]   abs_a, abs_b, div_diff, quo_neg, rem_neg;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [2*WIDTH-1:0] prod_neg;

  // acc is {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, operand};
    div_diff  = div_shift[WIDTH-1:0] - operand;
    prod_neg  = -acc;
    quo_neg   = -acc[WIDTH-1:0];
    rem_neg   = -acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    if (is_div) begin
      hi = neg_hi ? rem_neg : acc[2*WIDTH-1:WIDTH];
      lo = div_zero ? '1 : (neg_lo ? quo_neg : acc[WIDTH-1:0]);
    end else begin
      {hi, lo} = neg_lo ? prod_neg : acc;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIX) && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= ST_IDLE;
      iter     <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          iter     <= '0;
          is_div   <= op_div;
          neg_lo   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi   <= op_signed && op_div && a[WIDTH-1];
          div_zero <= op_div && (b == '0);
          acc      <= {{WIDTH{1'b0}}, op_div ? abs_a : abs_b};
          operand  <= op_div ? abs_b : abs_a;
          state    <= op_div ? ST_DIV : ST_MUL;
        end
        ST_MUL: begin
          acc  <= {mul_sum, acc[WIDTH-1:1]};
          iter <= iter + 1'b1;
          if (iter == SHW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_DIV: begin
          acc  <= {div_ge ? div_diff : div_shift[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
          iter <= iter + 1'b1;
          if (iter == SHW'(WIDTH - 1)) state <= ST_FIX;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// ALU with MIPS-style decode plus HI/LO registers fed by the iterative mul/div engine.
// ALU ops run combinationally even while the engine is busy; only mul/div-class ops stall.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst,
  alu_muldiv_unit_if.slave bus
);

  alu_ctl_e         ctl;
  logic             illegal_dec, ovf_en, use_shamt, is_md, md_start, md_busy, md_done;
  logic             add_ovf, sub_ovf;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sum, diff, alu_res, md_hi, md_lo, hi_q, lo_q;

  always_comb begin
    ctl         = CTL_ADD;
    illegal_dec = 1'b0;
    ovf_en      = 1'b0;
    use_shamt   = 1'b0;
    is_md       = 1'b0;
    case (bus.ALUOp)
      ALUOP_ADD:   ctl = CTL_ADD;
      ALUOP_SUB:   ctl = CTL_SUB;
      ALUOP_ANDI:  ctl = CTL_AND;
      ALUOP_ORI:   ctl = CTL_OR;
      ALUOP_XORI:  ctl = CTL_XOR;
      ALUOP_SLTI:  ctl = CTL_SLT;
      ALUOP_SLTIU: ctl = CTL_SLTU;
      ALUOP_RTYPE: begin
        case (bus.Funct)
          F_SLL:          begin ctl = CTL_SLL; use_shamt = 1'b1; end
          F_SRL:          begin ctl = CTL_SRL; use_shamt = 1'b1; end
          F_SRA:          begin ctl = CTL_SRA; use_shamt = 1'b1; end
          F_SLLV:         ctl = CTL_SLL;
          F_SRLV:         ctl = CTL_SRL;
          F_SRAV:         ctl = CTL_SRA;
          F_ADD:          begin ctl = CTL_ADD; ovf_en = 1'b1; end
          F_ADDU:         ctl = CTL_ADD;
          F_SUB:          begin ctl = CTL_SUB; ovf_en = 1'b1; end
          F_SUBU:         ctl = CTL_SUB;
          F_AND:          ctl = CTL_AND;
          F_OR:           ctl = CTL_OR;
          F_XOR:          ctl = CTL_XOR;
          F_NOR:          ctl = CTL_NOR;
          F_SLT:          ctl = CTL_SLT;
          F_SLTU:         ctl = CTL_SLTU;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: is_md = 1'b1;
          default:        illegal_dec = 1'b1;
        endcase
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  always_comb begin
    sh_amt  = use_shamt ? bus.shamt : bus.a[SHW-1:0];
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    case (ctl)
      CTL_AND:  alu_res = bus.a & bus.b;
      CTL_OR:   alu_res = bus.a | bus.b;
      CTL_XOR:  alu_res = bus.a ^ bus.b;
      CTL_NOR:  alu_res = ~(bus.a | bus.b);
      CTL_SUB:  alu_res = diff;
      CTL_SLTU: alu_res = WIDTH'(bus.a < bus.b);
      CTL_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      CTL_SLL:  alu_res = bus.b << sh_amt;
      CTL_SRL:  alu_res = bus.b >> sh_amt;
      CTL_SRA:  alu_res = WIDTH'($signed(bus.b) >>> sh_amt);
      default:  alu_res = sum;
    endcase
  end

  // Only MFHI/MFLO return data from the mul/div group; the rest report zero.
  always_comb begin
    if (!bus.in_valid)  bus.result = '0;
    else if (!is_md)    bus.result = alu_res;
    else if (bus.Funct == F_MFHI) bus.result = hi_q;
    else if (bus.Funct == F_MFLO) bus.result = lo_q;
    else                bus.result = '0;
  end

  assign bus.zero    = (bus.result == '0);
  assign bus.ovf     = bus.in_valid && ovf_en && ((ctl == CTL_SUB) ? sub_ovf : add_ovf);
  assign bus.illegal = bus.in_valid && illegal_dec;
  assign bus.busy    = md_busy;
  assign bus.stall   = bus.in_valid && md_busy && is_md;
  assign md_start    = bus.in_valid && is_md && !md_busy &&
                       (bus.Funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});

  muldiv_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .flush (bus.flush),
    .op    (md_op_e'(bus.Funct[1:0])),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo),
    .done  (md_done)
  );

  // Engine results land on the FIX->IDLE edge; MTHI/MTLO can only write when not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (bus.in_valid && is_md && !md_busy) begin
      if (bus.Funct == F_MTHI) hi_q <= bus.a;
      if (bus.Funct == F_MTLO) lo_q <= bus.a;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops
// and compares each instruction the unit accepts (in_valid and not stalled).
module tb_alu_muldiv_unit;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    string       name;
    logic        chk_res;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   sc, bc;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Issue one instruction and hold it while stalled; returns the number of stalled cycles.
  task automatic applyStimulus(input string name, input logic [3:0] aluop, input logic [5:0] funct,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] shamt,
                               input logic chk_res, input logic [31:0] res, input logic ovf,
                               input logic ill, output int stalled);
    exp_t e;
    logic st;
    e.name = name; e.chk_res = chk_res; e.res = res; e.ovf = ovf; e.ill = ill;
    exp_q.push_back(e);
    bus.ALUOp = aluop; bus.Funct = funct; bus.a = a; bus.b = b; bus.shamt = shamt;
    bus.in_valid = 1'b1;
    stalled = 0;
    forever begin
      @(negedge clk);
      st = bus.stall;
      @(posedge clk); #1;
      if (!st) break;
      stalled++;
      if (stalled > 200) begin
        checks++; errors++;
        $display("[TB] FAIL %s stall timeout got %0d cycles want < 200", name, stalled);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle(output int busy_cycles);
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cycles++;
      if (busy_cycles > 200) begin
        checks++; errors++;
        $display("[TB] FAIL busy timeout got %0d cycles want < 200", busy_cycles);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rtype(input string name, input logic [5:0] funct, input logic [31:0] a,
                       input logic [31:0] b, input logic chk_res, input logic [31:0] res);
    int s;
    applyStimulus(name, ALUOP_RTYPE, funct, a, b, 5'd0, chk_res, res, 1'b0, 1'b0, s);
  endtask

  // Monitor: compare every accepted instruction against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.in_valid && !bus.stall) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected accept got result %0h want no instruction", bus.result);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_res) begin
            checkOutput({e.name, " result"}, bus.result, e.res);
            checkOutput({e.name, " zero"}, bus.zero, e.res == 32'h0);
          end
          checkOutput({e.name, " ovf"}, bus.ovf, e.ovf);
          checkOutput({e.name, " illegal"}, bus.illegal, e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ALUOp = '0; bus.Funct = '0; bus.in_valid = 1'b0; bus.flush = 1'b0;
    bus.a = '0; bus.b = '0; bus.shamt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset stall", bus.stall, 0);
    checkOutput("reset illegal", bus.illegal, 0);
    checkOutput("reset result", bus.result, 0);
    @(posedge clk); #1;

    // Signed multiply: -3 * 7 = -21
    rtype("MULT", F_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 32'h0);
    waitIdle(bc);
    checkOutput("MULT busy cycles", bc, 33);
    rtype("MFLO mult", F_MFLO, 0, 0, 1'b1, 32'hFFFFFFEB);
    rtype("MFHI mult", F_MFHI, 0, 0, 1'b1, 32'hFFFFFFFF);

    // Signed divide: -7 / 2 = -3 rem -1
    rtype("DIV", F_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0);
    waitIdle(bc);
    rtype("MFLO div", F_MFLO, 0, 0, 1'b1, 32'hFFFFFFFD);
    rtype("MFHI div", F_MFHI, 0, 0, 1'b1, 32'hFFFFFFFF);

    // Divide by zero still takes the full latency
    rtype("DIVU by zero", F_DIVU, 32'd5, 32'd0, 1'b0, 32'h0);
    waitIdle(bc);
    checkOutput("DIVU0 busy cycles", bc, 33);
    rtype("MFLO div0", F_MFLO, 0, 0, 1'b1, 32'hFFFFFFFF);
    rtype("MFHI div0", F_MFHI, 0, 0, 1'b1, 32'h00000005);

    // Most-negative / -1
    rtype("DIV minneg", F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0);
    waitIdle(bc);
    rtype("MFLO minneg", F_MFLO, 0, 0, 1'b1, 32'h80000000);
    rtype("MFHI minneg", F_MFHI, 0, 0, 1'b1, 32'h00000000);

    // MFHI right behind MULTU stalls for the whole busy window
    rtype("MULTU", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0);
    applyStimulus("MFHI stalled", ALUOP_RTYPE, F_MFHI, 0, 0, 0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, sc);
    checkOutput("MFHI stall cycles", sc, 33);
    rtype("MFLO multu", F_MFLO, 0, 0, 1'b1, 32'h00000001);

    // Flush mid-divide keeps HI/LO
    rtype("MTHI", F_MTHI, 32'h11, 0, 1'b1, 32'h0);
    rtype("MTLO", F_MTLO, 32'h22, 0, 1'b1, 32'h0);
    rtype("DIV to flush", F_DIV, 32'd100, 32'd3, 1'b0, 32'h0);
    repeat (9) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("busy before flush", bus.busy, 1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("busy after flush", bus.busy, 0);
    @(posedge clk); #1;
    rtype("MFHI after flush", F_MFHI, 0, 0, 1'b1, 32'h11);
    rtype("MFLO after flush", F_MFLO, 0, 0, 1'b1, 32'h22);

    // Flush and start together: start ignored
    bus.flush = 1'b1;
    rtype("DIV with flush", F_DIV, 32'd9, 32'd2, 1'b0, 32'h0);
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("busy after flushed start", bus.busy, 0);
    @(posedge clk); #1;
    rtype("MFLO after flushed start", F_MFLO, 0, 0, 1'b1, 32'h22);

    // ALU vectors
    applyStimulus("ADD ovf", ALUOP_RTYPE, F_ADD, 32'h7FFFFFFF, 32'h1, 0, 1'b1, 32'h80000000, 1'b1, 1'b0, sc);
    applyStimulus("ADDU", ALUOP_RTYPE, F_ADDU, 32'h7FFFFFFF, 32'h1, 0, 1'b1, 32'h80000000, 1'b0, 1'b0, sc);
    applyStimulus("SUB ovf", ALUOP_RTYPE, F_SUB, 32'h80000000, 32'h1, 0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, sc);
    applyStimulus("SUBU", ALUOP_RTYPE, F_SUBU, 32'd5, 32'd7, 0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, sc);
    applyStimulus("SLTU", ALUOP_RTYPE, F_SLTU, 32'h1, 32'hFFFFFFFF, 0, 1'b1, 32'h1, 1'b0, 1'b0, sc);
    applyStimulus("SLT", ALUOP_RTYPE, F_SLT, 32'h1, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 1'b0, 1'b0, sc);
    applyStimulus("SRA", ALUOP_RTYPE, F_SRA, 32'h0, 32'h80000000, 5'd4, 1'b1, 32'hF8000000, 1'b0, 1'b0, sc);
    applyStimulus("SRLV", ALUOP_RTYPE, F_SRLV, 32'h8, 32'h80000000, 5'd0, 1'b1, 32'h00800000, 1'b0, 1'b0, sc);
    applyStimulus("SLL", ALUOP_RTYPE, F_SLL, 32'h0, 32'h1, 5'd31, 1'b1, 32'h80000000, 1'b0, 1'b0, sc);
    applyStimulus("NOR", ALUOP_RTYPE, F_NOR, 32'h0F0F0F0F, 32'hF0F00000, 0, 1'b1, 32'h0000F0F0, 1'b0, 1'b0, sc);
    applyStimulus("bad Funct", ALUOP_RTYPE, 6'b111111, 32'd3, 32'd4, 0, 1'b1, 32'd7, 1'b0, 1'b1, sc);
    applyStimulus("ALUOp SUB", ALUOP_SUB, 6'h0, 32'd3, 32'd3, 0, 1'b1, 32'h0, 1'b0, 1'b0, sc);
    applyStimulus("ALUOp ADD", ALUOP_ADD, 6'h0, 32'h7FFFFFFF, 32'h1, 0, 1'b1, 32'h80000000, 1'b0, 1'b0, sc);
    applyStimulus("XORI", ALUOP_XORI, 6'h0, 32'hF0, 32'hFF, 0, 1'b1, 32'h0F, 1'b0, 1'b0, sc);
    applyStimulus("ANDI", ALUOP_ANDI, 6'h0, 32'hFF00, 32'h0FF0, 0, 1'b1, 32'h0F00, 1'b0, 1'b0, sc);
    applyStimulus("SLTI", ALUOP_SLTI, 6'h0, 32'hFFFFFFFF, 32'h0, 0, 1'b1, 32'h1, 1'b0, 1'b0, sc);
    applyStimulus("bad ALUOp", 4'b0111, 6'h0, 32'd10, 32'd20, 0, 1'b1, 32'd30, 1'b0, 1'b1, sc);

    // ALU op executes without stalling while the engine is busy
    rtype("MULT 3x5", F_MULT, 32'd3, 32'd5, 1'b0, 32'h0);
    applyStimulus("ADD while busy", ALUOP_RTYPE, F_ADDU, 32'd40, 32'd2, 0, 1'b1, 32'd42, 1'b0, 1'b0, sc);
    checkOutput("ADD while busy stall cycles", sc, 0);
    waitIdle(bc);
    rtype("MFLO 3x5", F_MFLO, 0, 0, 1'b1, 32'd15);
    rtype("MFHI 3x5", F_MFHI, 0, 0, 1'b1, 32'd0);

    // Reset mid-multiply abandons the operation and clears HI/LO
    rtype("MTHI pre-reset", F_MTHI, 32'h55, 0, 1'b1, 32'h0);
    rtype("MTLO pre-reset", F_MTLO, 32'h66, 0, 1'b1, 32'h0);
    rtype("MULT to reset", F_MULT, 32'd3, 32'd5, 1'b0, 32'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("busy after mid reset", bus.busy, 0);
    @(posedge clk); #1;
    rtype("MFHI after reset", F_MFHI, 0, 0, 1'b1, 32'h0);
    rtype("MFLO after reset", F_MFLO, 0, 0, 1'b1, 32'h0);

    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32 or 64.
REQ-002 SHALL have derived parameter SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ALUOp  in  4  main-decoder op class: 0000 add, 0001 sub, 0010 R-type, 1xxx immediate.
REQ-006 Funct  in  6  R-type function field.
REQ-007 in_valid  in  1  instruction present this cycle.
REQ-008 flush  in  1  abort any in-flight mul/div.
REQ-009 a, b  in  WIDTH  operands (rs, rt/imm).
REQ-010 shamt  in  SHW  immediate shift amount.
REQ-011 result  out  WIDTH  ALU or MFHI/MFLO result, combinational.
REQ-012 zero, ovf, illegal  out  1 each  result==0; signed ADD/SUB overflow; unrecognised Funct.
REQ-013 busy, stall  out  1 each  mul/div FSM active; pipeline must hold the current instruction.

Function
REQ-014 SHALL decode the ALU ctl codes AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SLTU 0101, SUB 0110, SLT 0111, SLL 1000, SRL 1001 and SRA 1011.
REQ-015 ALUOp 0000 -> ADD; 0001 -> SUB; 1001/1010/1011/1100/1101 -> AND/OR/XOR/SLT/SLTU.
REQ-016 SHALL map R-type Funct: 000000/000100 SLL; 000010/000110 SRL; 000011/000111 SRA; 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU.
REQ-017 SHALL take the shift amount from shamt for the SLL/SRL/SRA Funct codes and from a[SHW-1:0] for the variable-shift codes; the value shifted is b.
REQ-018 Any unlisted Funct or ALUOp: ctl = ADD, illegal=1; decode SHALL be fully combinational with no inferred latches.
REQ-019 ovf SHALL be asserted only for Funct 100000 and 100010 on signed overflow; it SHALL be 0 otherwise.
REQ-020 Mul/div Funct codes: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO.
REQ-021 FSM states SHALL be IDLE, MUL, DIV and FIX.
REQ-022 IDLE -> MUL or DIV on in_valid & !busy & mult/div op; the SHALL capture operands, sign flags and op that edge.
REQ-023 MUL and DIV SHALL each run exactly WIDTH iterations (radix-2 shift-add, restoring divide), then enter FIX for 1 cycle (sign correction), then return to IDLE.
REQ-024 busy SHALL be 1 for exactly WIDTH+1 cycles; HI/LO SHALL be written on the FIX->IDLE edge and be readable the first cycle busy=0.
REQ-025 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-026 DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
REQ-027 DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-028 Divide by zero (DIV or DIVU): LO = all ones, HI = a; the block SHALL still take WIDTH+1 cycles.
REQ-029 MFHI/MFLO SHALL drive result = HI/LO; MTHI/MTLO SHALL write a to HI/LO at the edge, with result = 0.
REQ-030 stall = in_valid & busy & (any REQ-020 op); a stalled instruction SHALL have no effect.
REQ-031 ALU ops SHALL never stall and SHALL execute while busy.
REQ-032 flush SHALL force IDLE next edge and leave HI/LO unchanged; flush and start in the same cycle: flush wins, start ignored.
REQ-033 Flush during FIX: HI/LO SHALL NOT be written.

Reset
REQ-034 While rst=1 at an edge: state=IDLE, HI=LO=0, iteration counter=0; busy=0 the next cycle.
REQ-035 Reset mid-operation SHALL abandon the operation with no HI/LO write.
REQ-036 After reset, with in_valid=0: stall=0, illegal=0, result=0.

Structure
REQ-037 Package alu_pkg SHALL hold the ctl-code enum, ALUOp constants, Funct constants and the FSM state enum.
REQ-038 The iterative engine SHALL be sub-module muldiv_seq (clk, rst, start, flush, op, a, b -> busy, hi, lo, done); decode, ALU and HI/LO muxing SHALL be in the top level.

Verification (WIDTH=32)
REQ-039 Reset, then MULT a=0xFFFFFFFD b=7 -> busy 33 cycles; then MFLO=0xFFFFFFEB and MFHI=0xFFFFFFFF.
REQ-040 DIV a=0xFFFFFFF9 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=5 b=0 -> LO=0xFFFFFFFF, HI=5.
REQ-041 MFHI issued 1 cycle after MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall=1 until busy falls, then result=0xFFFFFFFE.
REQ-042 Start DIV, flush at iteration 10 -> busy=0 next cycle, HI/LO keep prior values (set by MTHI/MTLO to 0x11/0x22).
REQ-043 ALU: ADD 0x7FFFFFFF+1 -> ovf=1; SLTU 1,0xFFFFFFFF -> 1; SLT -> 0; SRA 0x80000000 by 4 -> 0xF8000000; Funct 111111 -> illegal=1, result=a+b.
REQ-044 Assert rst at MUL iteration 5 -> next cycle busy=0, HI=LO=0.
